button_debouncer: RTL and testbench
===================================

# button_debouncer

Multi-channel push-button debouncer and edge detector on the 100 MHz system clock. It synchronises raw board buttons and samples them on an internal ~190 Hz strobe, using a clock enable rather than a derived clock. Each output level changes only after STABLE_TICKS consecutive agreeing samples. It produces clean levels plus single-cycle press/release pulses that the CPU I/O and control logic consume directly on clk_100MHz.

## Interface
- N_BTN, 5, number of independent button channels (≥1)
- TICK_DIV, 524288, clk_100MHz cycles per sample strobe (2^19 → ~190.7 Hz; must be ≥2)
- STABLE_TICKS, 3, consecutive differing samples required to flip a debounced level (≥1)

Ports:
- clk_100MHz  in  1  system clock. Reset clr, asynchronous, active-high; clock clk_100MHz.
- clr  in  1  asynchronous active-high reset
- btn_raw  in  N_BTN  raw, asynchronous, bouncing button inputs (1 = pressed)
- btn_level  out  N_BTN  debounced level, registered
- btn_press  out  N_BTN  one-cycle pulse on a debounced 0→1 transition
- btn_release  out  N_BTN  one-cycle pulse on a debounced 1→0 transition
- tick  out  1  sample strobe, high for one cycle every TICK_DIV cycles (debug/observability)

## Operation
- Synchroniser: 2-FF per bit on btn_raw; sync output = second stage. Reset value 0.
- Tick counter, width $clog2(TICK_DIV):
  - counts 0..TICK_DIV-1 and wraps to 0
  - tick = (count == TICK_DIV-1), combinational from the register
- Per-channel stability counter cnt, width $clog2(STABLE_TICKS+1). Updated only on cycles with tick=1:
  - sync == btn_level → cnt <= 0
  - sync != btn_level and cnt < STABLE_TICKS-1 → cnt <= cnt+1
  - sync != btn_level and cnt == STABLE_TICKS-1 → btn_level <= sync, cnt <= 0, and btn_press (if sync=1) or btn_release (if sync=0) <= 1
- Pulses are registered and cleared to 0 on every clock edge not producing a flip; width is exactly 1 cycle.
- btn_press and btn_release are never high together on one channel.
- Channels are fully independent; any subset may flip on the same tick.
- A single differing sample followed by an agreeing one resets cnt. Bounces shorter than STABLE_TICKS consecutive samples never reach the outputs.
- Button held during reset: after clr deasserts, level rises normally and a btn_press pulse is emitted. This is intended.
- clr mid-operation: immediately clears the synchroniser, tick counter, all cnt, btn_level, btn_press and btn_release. No pulse is generated by reset.

## Timing
- Reset values: btn_level=0, btn_press=0, btn_release=0, tick=0 (counter=0).
- First tick: the cycle after the (TICK_DIV-1)th rising edge following clr deassertion. Thereafter period = TICK_DIV.
- On the edge closing a tick cycle: btn_level and the pulse register update together; the pulse is visible in the following cycle only.
- Input-to-output latency for a clean change, measured from btn_raw change to btn_level change:
  - minimum (STABLE_TICKS-1)·TICK_DIV + 3 cycles
  - maximum STABLE_TICKS·TICK_DIV + 2 cycles
  - the 2-cycle synchroniser delay is included
- Defaults give 10.5–15.7 ms.
- STABLE_TICKS=1 flips on the first differing sample.

## Test plan
Directed tests use N_BTN=2, TICK_DIV=4, STABLE_TICKS=3 unless stated.
- Reset/strobe: hold clr 3 cycles, btn_raw=0 → all outputs 0; tick high on cycles 4, 8, 12… after release; no pulses for 100 cycles.
- Clean press: btn_raw[0]=1 held → btn_level[0] rises on the 3rd tick after sync; btn_press[0]=1 for exactly 1 cycle; btn_release=0; channel 1 unchanged.
- Bounce reject: btn_raw[0] differs for 2 ticks, agrees for 1, repeated 5 times → btn_level[0] stays 0, no pulses. Then holding it for 3 ticks → single press pulse.
- Release + simultaneity: both channels debounced high, then both btn_raw drop on the same cycle → both btn_level fall on the same edge; btn_release=2'b11 for 1 cycle; btn_press=0.
- Reset mid-debounce: btn_raw[1]=1, assert clr after 2 ticks (cnt=2) → outputs 0 immediately, no pulse. After release, press requires a full 3 ticks again.
- STABLE_TICKS=1, TICK_DIV=2: a single sample flips the level; pulses stay 1 cycle wide and alternate press/release on a toggling input sampled every tick.

Source files
------------

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer: 2-FF synchroniser, clock-enable sample strobe,
// per-channel stability counter, and single-cycle press/release pulses on clk_100MHz.
module button_debouncer #(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned TICK_DIV     = 524288,
    parameter int unsigned STABLE_TICKS = 3
) (
    input  logic             clk_100MHz,
    input  logic             clr,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic             tick
);

    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

    logic [N_BTN-1:0]         sync_q1;
    logic [N_BTN-1:0]         sync_q2;
    logic [TW-1:0]            tick_cnt;
    logic [N_BTN-1:0][CW-1:0] cnt;
    logic [N_BTN-1:0][CW-1:0] cnt_next;
    logic [N_BTN-1:0]         level_next;
    logic [N_BTN-1:0]         press_next;
    logic [N_BTN-1:0]         release_next;

    // Raw buttons are asynchronous to the system clock.
    always_ff @(posedge clk_100MHz or posedge clr) begin
        if (clr) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Sample strobe generator; the strobe is a clock enable, not a derived clock.
    always_ff @(posedge clk_100MHz or posedge clr) begin
        if (clr) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // A channel flips only after STABLE_TICKS consecutive samples disagree with its level.
    always_comb begin
        cnt_next     = cnt;
        level_next   = btn_level;
        press_next   = '0;
        release_next = '0;
        if (tick) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (sync_q2[i] == btn_level[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt_next[i]     = '0;
                    level_next[i]   = sync_q2[i];
                    press_next[i]   = sync_q2[i];
                    release_next[i] = ~sync_q2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge clr) begin
        if (clr) begin
            cnt         <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            cnt         <= cnt_next;
            btn_level   <= level_next;
            btn_press   <= press_next;
            btn_release <= release_next;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed vector table and corner sequences on a slow-strobe
// instance, plus random stimulus on two instances checked against a sample-history model.
module tb_button_debouncer;

    logic       clk_100MHz = 1'b0;
    logic       clr;
    logic [1:0] raw_a, lvl_a, prs_a, rel_a;
    logic [1:0] raw_b, lvl_b, prs_b, rel_b;
    logic       tick_a, tick_b;

    always #5 clk_100MHz = ~clk_100MHz;

    button_debouncer #(.N_BTN(2), .TICK_DIV(4), .STABLE_TICKS(3)) dut_a (
        .clk_100MHz(clk_100MHz), .clr(clr), .btn_raw(raw_a),
        .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .tick(tick_a)
    );

    button_debouncer #(.N_BTN(2), .TICK_DIV(2), .STABLE_TICKS(1)) dut_b (
        .clk_100MHz(clk_100MHz), .clr(clr), .btn_raw(raw_b),
        .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .tick(tick_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw history gives the synchronised value; each channel keeps the samples taken
    // since its last flip and flips once the newest STABLE_TICKS of them all disagree.
    int         td [2] = '{4, 2};
    int         st [2] = '{3, 1};
    logic [1:0] hist [2][$];
    bit         smp [4][$];
    int         m_edges [2];
    logic [1:0] m_lvl [2];
    logic [1:0] m_prs [2];
    logic [1:0] m_rel [2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            hist[d].delete();
            hist[d].push_back(2'b00);
            hist[d].push_back(2'b00);
            m_edges[d] = 0;
            m_lvl[d]   = 2'b00;
            m_prs[d]   = 2'b00;
            m_rel[d]   = 2'b00;
        end
        for (int i = 0; i < 4; i++) smp[i].delete();
    endfunction

    function automatic void model_edge();
        logic [1:0] raw [2];
        logic [1:0] sample;
        int         idx;
        bit         all_diff;
        raw[0] = raw_a;
        raw[1] = raw_b;
        if (clr) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            sample   = hist[d][hist[d].size() - 2];
            m_prs[d] = 2'b00;
            m_rel[d] = 2'b00;
            if (m_edges[d] % td[d] == td[d] - 1) begin
                for (int ch = 0; ch < 2; ch++) begin
                    idx = d * 2 + ch;
                    smp[idx].push_back(sample[ch]);
                    if (smp[idx].size() > st[d]) void'(smp[idx].pop_front());
                    if (smp[idx].size() == st[d]) begin
                        all_diff = 1'b1;
                        for (int k = 0; k < smp[idx].size(); k++)
                            if (smp[idx][k] == m_lvl[d][ch]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_lvl[d][ch] = sample[ch];
                            m_prs[d][ch] = sample[ch];
                            m_rel[d][ch] = ~sample[ch];
                            smp[idx].delete();
                        end
                    end
                end
            end
            hist[d].push_back(raw[d]);
            if (hist[d].size() > 3) void'(hist[d].pop_front());
            m_edges[d]++;
        end
    endfunction

    int b_last = 2;

    task automatic compare_model();
        chk("mdl_lvl_a", 8'(lvl_a), 8'(m_lvl[0]));
        chk("mdl_prs_a", 8'(prs_a), 8'(m_prs[0]));
        chk("mdl_rel_a", 8'(rel_a), 8'(m_rel[0]));
        chk("mdl_tick_a", 8'(tick_a), 8'(m_edges[0] % td[0] == td[0] - 1));
        chk("mdl_lvl_b", 8'(lvl_b), 8'(m_lvl[1]));
        chk("mdl_prs_b", 8'(prs_b), 8'(m_prs[1]));
        chk("mdl_rel_b", 8'(rel_b), 8'(m_rel[1]));
        chk("mdl_tick_b", 8'(tick_b), 8'(m_edges[1] % td[1] == td[1] - 1));
        chk("excl_a", 8'(prs_a & rel_a), 8'd0);
        chk("excl_b", 8'(prs_b & rel_b), 8'd0);
        if (prs_b[0]) begin
            chk("alt_b_press", 8'(b_last), 8'd2);
            b_last = 1;
        end
        if (rel_b[0]) begin
            chk("alt_b_release", 8'(b_last), 8'd1);
            b_last = 2;
        end
    endtask

    bit b_toggle = 1'b1;

    task automatic step();
        @(posedge clk_100MHz);
        model_edge();
        #1;
        compare_model();
        if (clr) b_last = 2;
        if (b_toggle && (m_edges[1] % 2 == 0)) raw_b[0] = ~raw_b[0];
    endtask

    task automatic set_clr(input logic v);
        clr = v;
        #1;
        if (v) begin
            model_reset();
            b_last = 2;
            chk("clr_lvl_a", 8'(lvl_a), 8'd0);
            chk("clr_prs_a", 8'(prs_a), 8'd0);
            chk("clr_rel_a", 8'(rel_a), 8'd0);
            chk("clr_tick_a", 8'(tick_a), 8'd0);
            compare_model();
        end
    endtask

    typedef struct {
        logic [1:0] raw;
        int         n;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic       tck;
    } vec_t;

    vec_t tbl [12];
    int   npress;

    initial begin
        tbl[0]  = '{2'b00, 1,  2'b00, 2'b00, 2'b00, 1'b0};
        tbl[1]  = '{2'b00, 2,  2'b00, 2'b00, 2'b00, 1'b1};
        tbl[2]  = '{2'b01, 1,  2'b00, 2'b00, 2'b00, 1'b0};
        tbl[3]  = '{2'b01, 11, 2'b00, 2'b00, 2'b00, 1'b1};
        tbl[4]  = '{2'b01, 1,  2'b01, 2'b01, 2'b00, 1'b0};
        tbl[5]  = '{2'b01, 1,  2'b01, 2'b00, 2'b00, 1'b0};
        tbl[6]  = '{2'b11, 10, 2'b01, 2'b00, 2'b00, 1'b1};
        tbl[7]  = '{2'b11, 1,  2'b11, 2'b10, 2'b00, 1'b0};
        tbl[8]  = '{2'b00, 1,  2'b11, 2'b00, 2'b00, 1'b0};
        tbl[9]  = '{2'b00, 10, 2'b11, 2'b00, 2'b00, 1'b1};
        tbl[10] = '{2'b00, 1,  2'b00, 2'b00, 2'b11, 1'b0};
        tbl[11] = '{2'b00, 1,  2'b00, 2'b00, 2'b00, 1'b0};

        raw_a = 2'b00;
        raw_b = 2'b00;
        model_reset();
        set_clr(1'b1);
        repeat (3) step();
        chk("rst_lvl", 8'(lvl_a), 8'd0);
        chk("rst_tick", 8'(tick_a), 8'd0);
        set_clr(1'b0);

        // Directed vectors from reset release: strobe phase, clean press, simultaneous release.
        for (int i = 0; i < 12; i++) begin
            raw_a = tbl[i].raw;
            repeat (tbl[i].n) step();
            chk($sformatf("tbl%0d_lvl", i), 8'(lvl_a), 8'(tbl[i].lvl));
            chk($sformatf("tbl%0d_prs", i), 8'(prs_a), 8'(tbl[i].prs));
            chk($sformatf("tbl%0d_rel", i), 8'(rel_a), 8'(tbl[i].rel));
            chk($sformatf("tbl%0d_tick", i), 8'(tick_a), 8'(tbl[i].tck));
        end

        // Bounce: two disagreeing samples then one agreeing, five times.
        for (int r = 0; r < 5; r++) begin
            raw_a[0] = 1'b1;
            repeat (8) begin
                step();
                chk("bounce_lvl", 8'(lvl_a[0]), 8'd0);
                chk("bounce_prs", 8'(prs_a[0]), 8'd0);
            end
            raw_a[0] = 1'b0;
            repeat (4) begin
                step();
                chk("bounce_lvl", 8'(lvl_a[0]), 8'd0);
                chk("bounce_prs", 8'(prs_a[0]), 8'd0);
            end
        end
        raw_a[0] = 1'b1;
        npress   = 0;
        repeat (16) begin
            step();
            if (prs_a[0]) npress++;
        end
        chk("hold_press_cnt", 8'(npress), 8'd1);
        chk("hold_lvl", 8'(lvl_a[0]), 8'd1);
        raw_a[0] = 1'b0;
        repeat (16) step();
        chk("drop_lvl", 8'(lvl_a[0]), 8'd0);

        // Reset two samples into a debounce, then a full restart is required.
        set_clr(1'b1);
        repeat (2) step();
        raw_a = 2'b10;
        set_clr(1'b0);
        repeat (9) step();
        chk("mid_lvl_pre", 8'(lvl_a), 8'd0);
        set_clr(1'b1);
        repeat (2) begin
            step();
            chk("mid_clr_lvl", 8'(lvl_a), 8'd0);
            chk("mid_clr_prs", 8'(prs_a), 8'd0);
        end
        set_clr(1'b0);
        repeat (11) step();
        chk("mid_lvl_11", 8'(lvl_a), 8'd0);
        step();
        chk("mid_lvl_12", 8'(lvl_a), 8'b10);
        chk("mid_prs_12", 8'(prs_a), 8'b10);
        step();
        chk("mid_prs_13", 8'(prs_a), 8'd0);
        chk("mid_lvl_13", 8'(lvl_a), 8'b10);

        // Random stimulus on both instances with occasional resets.
        b_toggle = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 23) == 0) raw_a[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) raw_b[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 999) == 0) begin
                set_clr(1'b1);
                step();
                clr = 1'b0;
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
